// File: rtl/pwm_capture.sv
// PWM capture: measures the rise-to-rise period and rise-to-fall high time of an asynchronous
// PWM input in clock cycles, and flags a line that stops toggling (stuck high / stuck low).
module pwm_capture #(
  parameter int          CNT_W       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 16'hFFFF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PWM_IN,
  input  logic             CLEAR,
  output logic [CNT_W-1:0] PERIOD_VALUE,
  output logic [CNT_W-1:0] HIGH_VALUE,
  output logic             VALID,
  output logic             STUCK_HIGH,
  output logic             STUCK_LOW
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   primed;
  logic                   p;
  logic                   s;
  logic                   ready;
  logic                   rise;
  logic                   fall;
  logic                   timeout;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hi_lat;
  state_t                 state;

  // NOTE: the synchroniser flops get the async reset too, so s/p come out of reset at a known 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      p      <= 1'b0;
      primed <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PWM_IN};
      p      <= s;
      primed <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are ignored until the chain and p hold real samples, so a line already high at reset
  // release does not look like a rise: it must fall and rise again before a period is timed.
  assign s       = sync_q[SYNC_STAGES-1];
  assign ready   = primed[SYNC_STAGES];
  assign rise    = ready & s & ~p;
  assign fall    = ready & ~s & p;
  assign timeout = (cnt == TIMEOUT_C) && !rise && !fall;

  // NOTE: every register below uses non-blocking assignment so all of them see the same
  // pre-edge values of cnt/state; blocking here would chain updates within one edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      hi_lat       <= '0;
      PERIOD_VALUE <= '0;
      HIGH_VALUE   <= '0;
      VALID        <= 1'b0;
      STUCK_HIGH   <= 1'b0;
      STUCK_LOW    <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (CLEAR) begin
        state      <= ST_IDLE;
        cnt        <= '0;
        STUCK_HIGH <= 1'b0;
        STUCK_LOW  <= 1'b0;
      end else begin
        if (rise)                   cnt <= CNT_W'(1);
        else if (cnt != TIMEOUT_C)  cnt <= cnt + CNT_W'(1);

        if (timeout) begin
          // Saturated counter keeps re-asserting, so the flag tracks the current line level.
          STUCK_HIGH <= s;
          STUCK_LOW  <= ~s;
          state      <= ST_IDLE;
        end else begin
          unique case (state)
            ST_IDLE: if (rise) state <= ST_HIGH;
            ST_HIGH: if (fall) begin
              hi_lat <= cnt;
              state  <= ST_LOW;
            end
            ST_LOW: if (rise) begin
              PERIOD_VALUE <= cnt;
              HIGH_VALUE   <= hi_lat;
              VALID        <= 1'b1;
              STUCK_HIGH   <= 1'b0;
              STUCK_LOW    <= 1'b0;
              state        <= ST_HIGH;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: one instance with the default timeout for measurement tests,
// one with TIMEOUT=20 for the stuck-line tests; both share the same stimulus.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] period_l, high_l, period_t, high_t;
  logic        valid_l, stuck_high_l, stuck_low_l;
  logic        valid_t, stuck_high_t, stuck_low_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int nvalid_t = 0;
  int first_sh = -1;
  int vq_cyc[$];
  int vq_per[$];
  int vq_hi[$];

  always #5 clk = ~clk;

  pwm_capture dut_l (
    .CLK(clk), .RST_N(rst_n), .PWM_IN(pwm_in), .CLEAR(clear),
    .PERIOD_VALUE(period_l), .HIGH_VALUE(high_l), .VALID(valid_l),
    .STUCK_HIGH(stuck_high_l), .STUCK_LOW(stuck_low_l)
  );

  pwm_capture #(.TIMEOUT(20)) dut_t (
    .CLK(clk), .RST_N(rst_n), .PWM_IN(pwm_in), .CLEAR(clear),
    .PERIOD_VALUE(period_t), .HIGH_VALUE(high_t), .VALID(valid_t),
    .STUCK_HIGH(stuck_high_t), .STUCK_LOW(stuck_low_t)
  );

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic drive_cycle(input logic v);
    pwm_in = v;
    @(posedge clk);
    #1;
    cyc++;
    if (valid_l) begin
      vq_cyc.push_back(cyc);
      vq_per.push_back(int'(period_l));
      vq_hi.push_back(int'(high_l));
    end
    if (valid_t) nvalid_t++;
    if (stuck_high_t && first_sh < 0) first_sh = cyc;
  endtask

  task automatic run_pwm(input int hi, input int lo, input int periods);
    for (int k = 0; k < periods; k++) begin
      repeat (hi) drive_cycle(1'b1);
      repeat (lo) drive_cycle(1'b0);
    end
  endtask

  task automatic apply_reset(input logic level);
    pwm_in = level;
    clear  = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    vq_cyc.delete();
    vq_per.delete();
    vq_hi.delete();
  endtask

  task automatic test_reset();
    pwm_in = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (period_l !== 16'd0) begin n_bad++; $display("FAIL reset_period: got %0d expected 0", period_l); end
    n_cmp++; if (high_l !== 16'd0) begin n_bad++; $display("FAIL reset_high: got %0d expected 0", high_l); end
    n_cmp++; if (valid_l !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", valid_l); end
    n_cmp++; if (stuck_high_l !== 1'b0) begin n_bad++; $display("FAIL reset_stuck_high: got %b expected 0", stuck_high_l); end
    n_cmp++; if (stuck_low_l !== 1'b0) begin n_bad++; $display("FAIL reset_stuck_low: got %b expected 0", stuck_low_l); end
    rst_n = 1'b1;
  endtask

  // 3 high / 7 low, 5 periods: first rise only arms, rises 2..5 each report 10/3, 10 cycles apart.
  task automatic test_steady();
    apply_reset(1'b0);
    repeat (5) drive_cycle(1'b0);
    clear_log();
    run_pwm(3, 7, 5);
    n_cmp++; if (vq_per.size() !== 4) begin n_bad++; $display("FAIL steady_count: got %0d expected 4", vq_per.size()); end
    for (int i = 0; i < 4 && i < vq_per.size(); i++) begin
      n_cmp++; if (vq_per[i] !== 10) begin n_bad++; $display("FAIL steady_period[%0d]: got %0d expected 10", i, vq_per[i]); end
      n_cmp++; if (vq_hi[i] !== 3) begin n_bad++; $display("FAIL steady_high[%0d]: got %0d expected 3", i, vq_hi[i]); end
      if (i > 0) begin
        n_cmp++;
        if (vq_cyc[i] - vq_cyc[i-1] !== 10) begin
          n_bad++; $display("FAIL steady_spacing[%0d]: got %0d expected 10", i, vq_cyc[i] - vq_cyc[i-1]);
        end
      end
    end
  endtask

  // Continues from steady 3/7. The first new rise closes the last 3/7 period (10/3), then 8/2
  // periods report 10/8; the first 25-cycle rise closes the last 8/2 period, then 25/8.
  task automatic test_duty_change();
    int exp_per[6] = '{10, 10, 10, 10, 25, 25};
    int exp_hi[6]  = '{3, 8, 8, 8, 8, 8};
    clear_log();
    run_pwm(8, 2, 3);
    run_pwm(8, 17, 3);
    n_cmp++; if (vq_per.size() !== 6) begin n_bad++; $display("FAIL duty_count: got %0d expected 6", vq_per.size()); end
    for (int i = 0; i < 6 && i < vq_per.size(); i++) begin
      n_cmp++; if (vq_per[i] !== exp_per[i]) begin n_bad++; $display("FAIL duty_period[%0d]: got %0d expected %0d", i, vq_per[i], exp_per[i]); end
      n_cmp++; if (vq_hi[i] !== exp_hi[i]) begin n_bad++; $display("FAIL duty_high[%0d]: got %0d expected %0d", i, vq_hi[i], exp_hi[i]); end
    end
  endtask

  // TIMEOUT=20: line driven high at t0 is seen as a rise 2 edges later, cnt reaches 20 twenty
  // edges after that, and the flag registers on the next edge: first seen at t0+23.
  task automatic test_stuck_high();
    int t0;
    apply_reset(1'b0);
    repeat (5) drive_cycle(1'b0);
    run_pwm(3, 7, 2);
    nvalid_t = 0;
    first_sh = -1;
    t0 = cyc;
    repeat (40) drive_cycle(1'b1);
    n_cmp++; if (nvalid_t !== 1) begin n_bad++; $display("FAIL sh_valid_count: got %0d expected 1", nvalid_t); end
    n_cmp++; if (first_sh - t0 !== 23) begin n_bad++; $display("FAIL sh_onset: got %0d expected 23", first_sh - t0); end
    n_cmp++; if (stuck_high_t !== 1'b1) begin n_bad++; $display("FAIL sh_flag: got %b expected 1", stuck_high_t); end
    n_cmp++; if (stuck_low_t !== 1'b0) begin n_bad++; $display("FAIL sh_low_flag: got %b expected 0", stuck_low_t); end
    n_cmp++; if (period_t !== 16'd10) begin n_bad++; $display("FAIL sh_period_hold: got %0d expected 10", period_t); end
    n_cmp++; if (high_t !== 16'd3) begin n_bad++; $display("FAIL sh_high_hold: got %0d expected 3", high_t); end
    repeat (7) drive_cycle(1'b0);
    n_cmp++; if (stuck_low_t !== 1'b1) begin n_bad++; $display("FAIL sh_to_sl_low: got %b expected 1", stuck_low_t); end
    n_cmp++; if (stuck_high_t !== 1'b0) begin n_bad++; $display("FAIL sh_to_sl_high: got %b expected 0", stuck_high_t); end
    nvalid_t = 0;
    run_pwm(3, 7, 1);
    n_cmp++; if (stuck_low_t !== 1'b1) begin n_bad++; $display("FAIL sl_hold_until_valid: got %b expected 1", stuck_low_t); end
    n_cmp++; if (nvalid_t !== 0) begin n_bad++; $display("FAIL sl_rearm_valid: got %0d expected 0", nvalid_t); end
    run_pwm(3, 7, 1);
    n_cmp++; if (nvalid_t !== 1) begin n_bad++; $display("FAIL resume_valid: got %0d expected 1", nvalid_t); end
    n_cmp++; if (stuck_low_t !== 1'b0) begin n_bad++; $display("FAIL resume_stuck_low: got %b expected 0", stuck_low_t); end
    n_cmp++; if (stuck_high_t !== 1'b0) begin n_bad++; $display("FAIL resume_stuck_high: got %b expected 0", stuck_high_t); end
    n_cmp++; if (period_t !== 16'd10 || high_t !== 16'd3) begin
      n_bad++; $display("FAIL resume_values: got %0d/%0d expected 10/3", period_t, high_t);
    end
  endtask

  task automatic test_stuck_from_reset();
    apply_reset(1'b0);
    nvalid_t = 0;
    repeat (30) drive_cycle(1'b0);
    n_cmp++; if (stuck_low_t !== 1'b1) begin n_bad++; $display("FAIL rl_stuck_low: got %b expected 1", stuck_low_t); end
    n_cmp++; if (stuck_high_t !== 1'b0) begin n_bad++; $display("FAIL rl_stuck_high: got %b expected 0", stuck_high_t); end
    n_cmp++; if (nvalid_t !== 0) begin n_bad++; $display("FAIL rl_valid: got %0d expected 0", nvalid_t); end
    n_cmp++; if (period_t !== 16'd0) begin n_bad++; $display("FAIL rl_period: got %0d expected 0", period_t); end
    apply_reset(1'b1);
    nvalid_t = 0;
    repeat (30) drive_cycle(1'b1);
    n_cmp++; if (stuck_high_t !== 1'b1) begin n_bad++; $display("FAIL rh_stuck_high: got %b expected 1", stuck_high_t); end
    n_cmp++; if (stuck_low_t !== 1'b0) begin n_bad++; $display("FAIL rh_stuck_low: got %b expected 0", stuck_low_t); end
    n_cmp++; if (nvalid_t !== 0) begin n_bad++; $display("FAIL rh_valid: got %0d expected 0", nvalid_t); end
  endtask

  // CLEAR in LOW of a 10-cycle period: the rise ending it only re-arms, so the two VALIDs around
  // it (segment drive 0 and drive 20) are observed 20 cycles apart, at t0+3 and t0+23.
  task automatic test_clear();
    int t0;
    apply_reset(1'b0);
    repeat (5) drive_cycle(1'b0);
    run_pwm(3, 7, 3);
    clear_log();
    t0 = cyc;
    repeat (3) drive_cycle(1'b1);
    repeat (4) drive_cycle(1'b0);
    clear = 1'b1;
    drive_cycle(1'b0);
    clear = 1'b0;
    n_cmp++; if (valid_l !== 1'b0) begin n_bad++; $display("FAIL clr_valid: got %b expected 0", valid_l); end
    n_cmp++; if (period_l !== 16'd10 || high_l !== 16'd3) begin
      n_bad++; $display("FAIL clr_hold: got %0d/%0d expected 10/3", period_l, high_l);
    end
    repeat (2) drive_cycle(1'b0);
    run_pwm(3, 7, 2);
    n_cmp++; if (vq_cyc.size() !== 2) begin n_bad++; $display("FAIL clr_count: got %0d expected 2", vq_cyc.size()); end
    if (vq_cyc.size() >= 2) begin
      n_cmp++; if (vq_cyc[0] - t0 !== 3) begin n_bad++; $display("FAIL clr_first_at: got %0d expected 3", vq_cyc[0] - t0); end
      n_cmp++; if (vq_cyc[1] - t0 !== 23) begin n_bad++; $display("FAIL clr_next_at: got %0d expected 23", vq_cyc[1] - t0); end
      n_cmp++; if (vq_per[1] !== 10 || vq_hi[1] !== 3) begin
        n_bad++; $display("FAIL clr_next_values: got %0d/%0d expected 10/3", vq_per[1], vq_hi[1]);
      end
    end
  endtask

  // Reset pulse between edges while high; the partial period after release must not be reported.
  task automatic test_async_reset();
    int t0;
    repeat (2) drive_cycle(1'b1);
    rst_n = 1'b0;
    #3;
    n_cmp++; if (period_l !== 16'd0) begin n_bad++; $display("FAIL ar_period: got %0d expected 0", period_l); end
    n_cmp++; if (high_l !== 16'd0) begin n_bad++; $display("FAIL ar_high: got %0d expected 0", high_l); end
    n_cmp++; if (valid_l !== 1'b0) begin n_bad++; $display("FAIL ar_valid: got %b expected 0", valid_l); end
    n_cmp++; if (stuck_high_l !== 1'b0 || stuck_low_l !== 1'b0) begin
      n_bad++; $display("FAIL ar_stuck: got %b%b expected 00", stuck_high_l, stuck_low_l);
    end
    #2;
    rst_n = 1'b1;
    clear_log();
    t0 = cyc;
    drive_cycle(1'b1);
    repeat (7) drive_cycle(1'b0);
    run_pwm(3, 7, 3);
    n_cmp++; if (vq_cyc.size() !== 2) begin n_bad++; $display("FAIL ar_count: got %0d expected 2", vq_cyc.size()); end
    for (int i = 0; i < 2 && i < vq_cyc.size(); i++) begin
      n_cmp++; if (vq_per[i] !== 10 || vq_hi[i] !== 3) begin
        n_bad++; $display("FAIL ar_values[%0d]: got %0d/%0d expected 10/3", i, vq_per[i], vq_hi[i]);
      end
      n_cmp++; if (vq_cyc[i] - t0 !== 21 + 10 * i) begin
        n_bad++; $display("FAIL ar_at[%0d]: got %0d expected %0d", i, vq_cyc[i] - t0, 21 + 10 * i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_duty_change();
    test_stuck_high();
    test_stuck_from_reset();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
